// File: rtl/rgb_lab_pkg.sv
// Shared definitions for the post colour-matrix stages: default latency,
// channel-format bit positions and the channel clamp/clip helpers.
package rgb_lab_pkg;

  localparam int LAT_DEFAULT   = 4;
  localparam int DSIZE_DEFAULT = 8;
  localparam int CH_MAX_W      = 16;

  // Matrix result layout: {sign, overflow, DSIZE magnitude bits}
  localparam int SIGN_OFS = 1;
  localparam int OVF_OFS  = 0;
  localparam int SIGN_IDX = DSIZE_DEFAULT + SIGN_OFS;
  localparam int OVF_IDX  = DSIZE_DEFAULT + OVF_OFS;

  function automatic logic [CH_MAX_W-1:0] clamp_ch(input logic [CH_MAX_W+1:0] x,
                                                   input int unsigned dsize);
    logic [1:0]          hi;
    logic [CH_MAX_W-1:0] mask;
    hi   = 2'(x >> dsize);
    mask = {CH_MAX_W{1'b1}} >> (CH_MAX_W - dsize);
    if (hi[SIGN_OFS])     clamp_ch = '0;
    else if (hi[OVF_OFS]) clamp_ch = mask;
    else                  clamp_ch = x[CH_MAX_W-1:0] & mask;
  endfunction

  function automatic logic clip_ch(input logic [CH_MAX_W+1:0] x,
                                   input int unsigned dsize);
    logic [1:0] hi;
    hi      = 2'(x >> dsize);
    clip_ch = |hi;
  endfunction

endpackage

// File: rtl/ctrl_delay_line.sv
// Fixed-depth shift register used to keep video sync aligned with a
// pipelined datapath. Asynchronous active-low reset clears every stage.
module ctrl_delay_line #(
  parameter int W     = 3,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] sr_q [DEPTH];

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    end else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/rgb_clamp_align.sv
// Saturates signed colour-matrix results to unsigned DSIZE and realigns vs/hs/de.
// Define RGB_CLAMP_CLIP_STAT_EN to build the per-frame clipped-pixel counter.
module rgb_clamp_align
  import rgb_lab_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEFAULT,
  parameter int LAT   = LAT_DEFAULT,
  parameter int CNT_W = 20
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic                    i_vs,
  input  logic                    i_hs,
  input  logic                    i_de,
  input  logic signed [DSIZE+1:0] iR,
  input  logic signed [DSIZE+1:0] iG,
  input  logic signed [DSIZE+1:0] iB,
  output logic [DSIZE-1:0]        oR,
  output logic [DSIZE-1:0]        oG,
  output logic [DSIZE-1:0]        oB,
  output logic                    o_vs,
  output logic                    o_hs,
  output logic                    o_de,
  output logic [CNT_W-1:0]        clip_cnt,
  output logic                    clip_cnt_vld
);

  logic [2:0]       ctrl_tap;
  logic [2:0]       ctrl_q;
  logic [DSIZE-1:0] r_d, g_d, b_d;
  logic [DSIZE-1:0] r_q, g_q, b_q;

  // Tap is {vs,hs,de} aligned with the current iR/iG/iB
  ctrl_delay_line #(.W(3), .DEPTH(LAT)) u_ctrl_dly (
    .clock (clock),
    .rst_n (rst_n),
    .d_i   ({i_vs, i_hs, i_de}),
    .q_o   (ctrl_tap)
  );

  always_comb begin
    r_d = DSIZE'(clamp_ch((CH_MAX_W+2)'(iR), DSIZE));
    g_d = DSIZE'(clamp_ch((CH_MAX_W+2)'(iG), DSIZE));
    b_d = DSIZE'(clamp_ch((CH_MAX_W+2)'(iB), DSIZE));
  end

  // Clamp stage: data and sync leave together, LAT+1 after the sync input
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      r_q    <= '0;
      g_q    <= '0;
      b_q    <= '0;
    end else begin
      ctrl_q <= ctrl_tap;
      r_q    <= r_d;
      g_q    <= g_d;
      b_q    <= b_d;
    end
  end

  assign oR   = r_q;
  assign oG   = g_q;
  assign oB   = b_q;
  assign o_vs = ctrl_q[2];
  assign o_hs = ctrl_q[1];
  assign o_de = ctrl_q[0];

`ifdef RGB_CLAMP_CLIP_STAT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             clip_ev, vs_rise;
  logic             vs_prev_q, armed_q, vld_q;
  logic [CNT_W-1:0] cnt_d, cnt_q, clip_cnt_q;

  assign clip_ev = ctrl_tap[0] & (clip_ch((CH_MAX_W+2)'(iR), DSIZE) |
                                  clip_ch((CH_MAX_W+2)'(iG), DSIZE) |
                                  clip_ch((CH_MAX_W+2)'(iB), DSIZE));
  assign vs_rise = ctrl_tap[2] & ~vs_prev_q;

  // A clipped pixel on the frame-start cycle belongs to the new frame
  always_comb begin
    cnt_d = cnt_q;
    if (vs_rise)                          cnt_d = clip_ev ? CNT_W'(1) : '0;
    else if (clip_ev && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev_q  <= 1'b0;
      armed_q    <= 1'b0;
      vld_q      <= 1'b0;
      cnt_q      <= '0;
      clip_cnt_q <= '0;
    end else begin
      vs_prev_q <= ctrl_tap[2];
      cnt_q     <= cnt_d;
      vld_q     <= vs_rise & armed_q;
      if (vs_rise) begin
        armed_q <= 1'b1;
        if (armed_q) clip_cnt_q <= cnt_q;
      end
    end
  end

  assign clip_cnt     = clip_cnt_q;
  assign clip_cnt_vld = vld_q;
`else
  assign clip_cnt     = '0;
  assign clip_cnt_vld = 1'b0;
`endif

endmodule

// File: tb/tb_rgb_clamp_align.sv
// Self-checking bench for rgb_clamp_align: randomized pixels against a
// frame-level reference model; a second instance uses a 4-bit clip counter.
module tb_rgb_clamp_align;

  localparam int DSIZE = 8;
  localparam int LAT   = 4;
  localparam int NCYC  = 8192;
`ifdef RGB_CLAMP_CLIP_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  typedef struct {
    logic       vs, hs, de;
    logic [9:0] r, g, b;
  } px_t;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  logic              i_vs = 1'b0, i_hs = 1'b0, i_de = 1'b0;
  logic signed [9:0] iR = '0, iG = '0, iB = '0;
  logic [7:0]        oR, oG, oB, sR, sG, sB;
  logic              o_vs, o_hs, o_de, s_vs, s_hs, s_de;
  logic [19:0]       clip_cnt;
  logic              clip_cnt_vld;
  logic [3:0]        sat_cnt;
  logic              sat_vld;

  rgb_clamp_align #(.DSIZE(DSIZE), .LAT(LAT), .CNT_W(20)) u_dut (
    .clock(clock), .rst_n(rst_n), .i_vs(i_vs), .i_hs(i_hs), .i_de(i_de),
    .iR(iR), .iG(iG), .iB(iB), .oR(oR), .oG(oG), .oB(oB),
    .o_vs(o_vs), .o_hs(o_hs), .o_de(o_de),
    .clip_cnt(clip_cnt), .clip_cnt_vld(clip_cnt_vld)
  );

  rgb_clamp_align #(.DSIZE(DSIZE), .LAT(LAT), .CNT_W(4)) u_sat (
    .clock(clock), .rst_n(rst_n), .i_vs(i_vs), .i_hs(i_hs), .i_de(i_de),
    .iR(iR), .iG(iG), .iB(iB), .oR(sR), .oG(sG), .oB(sB),
    .o_vs(s_vs), .o_hs(s_hs), .o_de(s_de),
    .clip_cnt(sat_cnt), .clip_cnt_vld(sat_vld)
  );

  // Stimulus record, indexed by the cycle the pixel's sync was presented
  logic       pv [NCYC];
  logic       ph [NCYC];
  logic       pd [NCYC];
  logic [9:0] pr [NCYC];
  logic [9:0] pg [NCYC];
  logic [9:0] pb [NCYC];

  int   cyc = 0;
  int   base = 0;
  bit   in_rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   m_last_rise = -1;
  logic [19:0] m_rep20 = '0;
  logic [3:0]  m_rep4 = '0;

  logic [2:0] exp_ctrl;
  logic [7:0] exp_r, exp_g, exp_b;
  logic       exp_vld;

  px_t q_px[$];

  function automatic int sval(input logic [9:0] v);
    return v[9] ? int'(v) - 1024 : int'(v);
  endfunction

  function automatic logic [7:0] clamp_ref(input logic [9:0] v);
    int s = sval(v);
    if (s < 0)   return 8'd0;
    if (s > 255) return 8'd255;
    return 8'(s);
  endfunction

  function automatic bit is_clip(input logic [9:0] v);
    int s = sval(v);
    return (s < 0) || (s > 255);
  endfunction

  function automatic bit clip_px(input int q);
    return pd[q] && (is_clip(pr[q]) || is_clip(pg[q]) || is_clip(pb[q]));
  endfunction

  function automatic logic [9:0] rnd_ch();
    case ($urandom_range(0, 3))
      0:       return 10'($urandom_range(512, 1023));
      1:       return 10'($urandom_range(256, 511));
      default: return 10'($urandom_range(0, 255));
    endcase
  endfunction

  function automatic px_t rnd_px(input logic vs);
    px_t px;
    px.vs = vs; px.hs = 1'($urandom); px.de = 1'($urandom);
    px.r = rnd_ch(); px.g = rnd_ch(); px.b = rnd_ch();
    return px;
  endfunction

  function automatic px_t good_px();
    px_t px;
    px.vs = 1'b0; px.hs = 1'b0; px.de = 1'b1;
    px.r = 10'($urandom_range(0, 255));
    px.g = 10'($urandom_range(0, 255));
    px.b = 10'($urandom_range(0, 255));
    return px;
  endfunction

  // Drive one cycle (sync now, matrix data LAT cycles later) and compute the
  // outputs expected just after the clock edge.
  task automatic tick(input px_t px);
    int   p, n;
    logic prev;
    pv[cyc] = px.vs; ph[cyc] = px.hs; pd[cyc] = px.de;
    pr[cyc] = px.r;  pg[cyc] = px.g;  pb[cyc] = px.b;
    i_vs = px.vs; i_hs = px.hs; i_de = px.de;
    p = cyc - LAT;
    if (in_rst) begin
      iR = 10'($urandom); iG = 10'($urandom); iB = 10'($urandom);
    end else if (p >= base) begin
      iR = pr[p]; iG = pg[p]; iB = pb[p];
    end else begin
      iR = '0; iG = '0; iB = '0;
    end
    exp_vld = 1'b0;
    if (!in_rst && p >= base) begin
      exp_ctrl = {pv[p], ph[p], pd[p]};
      exp_r = clamp_ref(pr[p]); exp_g = clamp_ref(pg[p]); exp_b = clamp_ref(pb[p]);
      prev = (p - 1 >= base) ? pv[p-1] : 1'b0;
      if (pv[p] && !prev) begin
        if (m_last_rise >= 0) begin
          n = 0;
          for (int q = m_last_rise; q < p; q++) if (clip_px(q)) n++;
          m_rep20 = STAT ? 20'((n > 1048575) ? 1048575 : n) : 20'd0;
          m_rep4  = STAT ? 4'((n > 15) ? 15 : n) : 4'd0;
          exp_vld = STAT;
        end
        m_last_rise = p;
      end
    end else begin
      exp_ctrl = '0; exp_r = '0; exp_g = '0; exp_b = '0;
    end
    if (in_rst) begin
      m_rep20 = '0; m_rep4 = '0; m_last_rise = -1;
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    px_t px;
    rst_n = 1'b0; in_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin px = rnd_px(1'($urandom)); tick(px); end
    rst_n = 1'b1; in_rst = 1'b0; base = cyc;
  endtask

  task automatic push_frame(input int nclip, input int nact);
    px_t px;
    int  left = nclip;
    for (int k = 0; k < 3; k++) begin px = rnd_px(1'b1); px.de = 1'b0; px.hs = (k == 0); q_px.push_back(px); end
    for (int k = 0; k < 4; k++) begin px = rnd_px(1'b0); px.de = 1'b0; q_px.push_back(px); end
    for (int k = 0; k < nact; k++) begin
      px = good_px();
      if (left > 0 && (k % 3 == 0)) begin
        case (left % 3)
          0:       px.r = 10'h300;
          1:       px.g = 10'h1A0;
          default: begin px.r = 10'h200; px.g = 10'h100; px.b = 10'h3FF; end
        endcase
        left--;
      end
      q_px.push_back(px);
    end
    for (int k = 0; k < 3; k++) begin
      px = rnd_px(1'b0); px.de = 1'b0; px.r = 10'h180; px.g = 10'h3C0; q_px.push_back(px);
    end
  endtask

  task automatic test_reset();
    px_t px;
    rst_n = 1'b0; in_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      px = rnd_px(1'($urandom));
      tick(px);
      n_chk++;
      if ({oR, oG, oB, o_vs, o_hs, o_de, clip_cnt_vld, sat_vld} !== '0 || clip_cnt !== '0 || sat_cnt !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: got R=%0d G=%0d B=%0d vs=%b hs=%b de=%b cnt=%0d vld=%b, required all 0",
                 oR, oG, oB, o_vs, o_hs, o_de, clip_cnt, clip_cnt_vld);
      end
    end
    rst_n = 1'b1; in_rst = 1'b0; base = cyc;
    for (int i = 0; i < 20; i++) begin
      px = '{vs: 1'b0, hs: 1'b0, de: (i == 10), r: '0, g: '0, b: '0};
      tick(px);
      n_chk++;
      if (o_de !== ((i + 1) == (10 + LAT + 1))) begin
        n_fail++;
        $display("FAIL de_latency: cycle %0d got o_de=%b, required %b", i + 1, o_de, (i + 1) == (10 + LAT + 1));
      end
    end
  endtask

  task automatic test_clamp();
    px_t dir[$];
    px_t px;
    dir.push_back('{vs: 1'b0, hs: 1'b1, de: 1'b1, r: 10'h3F0, g: 10'h120, b: 10'h07F});
    dir.push_back('{vs: 1'b0, hs: 1'b0, de: 1'b1, r: 10'h0FF, g: 10'h200, b: 10'h1FF});
    dir.push_back('{vs: 1'b0, hs: 1'b0, de: 1'b1, r: 10'h100, g: 10'h000, b: 10'h0FF});
    for (int i = 0; i < LAT + 4; i++) begin
      px = (i < 3) ? dir[i] : '{vs: 1'b0, hs: 1'b0, de: 1'b0, r: '0, g: '0, b: '0};
      tick(px);
      n_chk++;
      if ({oR, oG, oB, o_vs, o_hs, o_de} !== {exp_r, exp_g, exp_b, exp_ctrl}) begin
        n_fail++;
        $display("FAIL clamp_directed: step %0d got %0d/%0d/%0d ctrl=%b, required %0d/%0d/%0d ctrl=%b",
                 i, oR, oG, oB, {o_vs, o_hs, o_de}, exp_r, exp_g, exp_b, exp_ctrl);
      end
      if (i == LAT) begin
        n_chk++;
        if ({oR, oG, oB} !== {8'd0, 8'd255, 8'd127}) begin
          n_fail++;
          $display("FAIL clamp_basic: got %0d/%0d/%0d, required 0/255/127", oR, oG, oB);
        end
      end
      if (i == LAT + 1 || i == LAT + 2) begin
        n_chk++;
        if (oR !== 8'd255) begin
          n_fail++;
          $display("FAIL clamp_boundary: step %0d got oR=%0d, required 255", i, oR);
        end
      end
    end
  endtask

  task automatic test_random();
    px_t px;
    for (int i = 0; i < 400; i++) begin
      px = rnd_px((i % 50) < 3);
      tick(px);
      n_chk++;
      if ({oR, oG, oB, o_vs, o_hs, o_de} !== {exp_r, exp_g, exp_b, exp_ctrl} ||
          {sR, sG, sB, s_vs, s_hs, s_de} !== {exp_r, exp_g, exp_b, exp_ctrl}) begin
        n_fail++;
        $display("FAIL random_data: cycle %0d got %0d/%0d/%0d ctrl=%b, required %0d/%0d/%0d ctrl=%b",
                 cyc, oR, oG, oB, {o_vs, o_hs, o_de}, exp_r, exp_g, exp_b, exp_ctrl);
      end
      n_chk++;
      if (clip_cnt_vld !== exp_vld || clip_cnt !== m_rep20 || sat_vld !== exp_vld || sat_cnt !== m_rep4) begin
        n_fail++;
        $display("FAIL random_stat: cycle %0d got vld=%b cnt=%0d sat=%0d, required vld=%b cnt=%0d sat=%0d",
                 cyc, clip_cnt_vld, clip_cnt, sat_cnt, exp_vld, m_rep20, m_rep4);
      end
    end
  endtask

  task automatic test_frames();
    px_t  px;
    int   reps[$];
    int   want[3] = '{0, 5, 0};
    apply_reset();
    push_frame(0, 20); push_frame(5, 20); push_frame(0, 20); push_frame(0, 4);
    while (q_px.size() > 0) begin
      px = q_px.pop_front();
      tick(px);
      if (clip_cnt_vld === 1'b1) reps.push_back(int'(clip_cnt));
      n_chk++;
      if (clip_cnt_vld !== exp_vld || clip_cnt !== m_rep20 || o_de !== exp_ctrl[0]) begin
        n_fail++;
        $display("FAIL frame_stat: cycle %0d got vld=%b cnt=%0d de=%b, required vld=%b cnt=%0d de=%b",
                 cyc, clip_cnt_vld, clip_cnt, o_de, exp_vld, m_rep20, exp_ctrl[0]);
      end
    end
    n_chk++;
    if (reps.size() !== (STAT ? 3 : 0)) begin
      n_fail++;
      $display("FAIL frame_reports: got %0d reports, required %0d", reps.size(), STAT ? 3 : 0);
    end
    for (int i = 0; i < reps.size() && i < 3; i++) begin
      n_chk++;
      if (reps[i] !== want[i]) begin
        n_fail++;
        $display("FAIL frame_count: report %0d got %0d, required %0d", i, reps[i], want[i]);
      end
    end
  endtask

  task automatic test_coincident();
    px_t px;
    int  last = 0;
    apply_reset();
    push_frame(0, 5);
    q_px.push_back('{vs: 1'b1, hs: 1'b1, de: 1'b1, r: 10'h300, g: 10'h010, b: 10'h020});
    for (int k = 0; k < 6; k++) q_px.push_back(good_px());
    push_frame(0, 5);
    while (q_px.size() > 0) begin
      px = q_px.pop_front();
      tick(px);
      if (clip_cnt_vld === 1'b1) last = int'(clip_cnt);
      n_chk++;
      if (clip_cnt_vld !== exp_vld || clip_cnt !== m_rep20) begin
        n_fail++;
        $display("FAIL coincident_stat: cycle %0d got vld=%b cnt=%0d, required vld=%b cnt=%0d",
                 cyc, clip_cnt_vld, clip_cnt, exp_vld, m_rep20);
      end
    end
    n_chk++;
    if (last !== (STAT ? 1 : 0)) begin
      n_fail++;
      $display("FAIL coincident_count: got %0d, required %0d", last, STAT ? 1 : 0);
    end
  endtask

  task automatic test_saturation();
    px_t px;
    apply_reset();
    push_frame(0, 3); push_frame(20, 64); push_frame(0, 3);
    while (q_px.size() > 0) begin
      px = q_px.pop_front();
      tick(px);
      n_chk++;
      if (sat_vld !== exp_vld || sat_cnt !== m_rep4) begin
        n_fail++;
        $display("FAIL saturation_stat: cycle %0d got vld=%b cnt=%0d, required vld=%b cnt=%0d",
                 cyc, sat_vld, sat_cnt, exp_vld, m_rep4);
      end
    end
    n_chk++;
    if (sat_cnt !== (STAT ? 4'd15 : 4'd0) || clip_cnt !== (STAT ? 20'd20 : 20'd0)) begin
      n_fail++;
      $display("FAIL saturation_count: got sat=%0d wide=%0d, required sat=%0d wide=%0d",
               sat_cnt, clip_cnt, STAT ? 15 : 0, STAT ? 20 : 0);
    end
  endtask

  task automatic test_reset_midframe();
    px_t px;
    int  reps[$];
    push_frame(0, 5);
    for (int k = 0; k < 10; k++) begin
      px = good_px();
      if (k % 4 == 1) px.b = 10'h2A0;
      q_px.push_back(px);
    end
    while (q_px.size() > 0) begin px = q_px.pop_front(); tick(px); end
    apply_reset();
    push_frame(2, 10); push_frame(0, 5);
    while (q_px.size() > 0) begin
      px = q_px.pop_front();
      tick(px);
      if (clip_cnt_vld === 1'b1) reps.push_back(int'(clip_cnt));
      n_chk++;
      if (clip_cnt_vld !== exp_vld || clip_cnt !== m_rep20) begin
        n_fail++;
        $display("FAIL midreset_stat: cycle %0d got vld=%b cnt=%0d, required vld=%b cnt=%0d",
                 cyc, clip_cnt_vld, clip_cnt, exp_vld, m_rep20);
      end
    end
    n_chk++;
    if (reps.size() !== (STAT ? 1 : 0)) begin
      n_fail++;
      $display("FAIL midreset_reports: got %0d reports, required %0d", reps.size(), STAT ? 1 : 0);
    end
    for (int i = 0; i < reps.size(); i++) begin
      n_chk++;
      if (reps[i] !== 2) begin
        n_fail++;
        $display("FAIL midreset_count: got %0d, required 2", reps[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clamp();
    test_random();
    test_frames();
    test_coincident();
    test_saturation();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
